// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: memory-mapped GPIO with switch readback, debounced keys,
// a byte-writable LED register and per-key edge interrupts.
module gpio_irq_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h7f60,
   parameter int          NKEY      = 8,
   parameter int          LED_W     = 32,
   parameter int          DB_CYCLES = 1000,
   parameter int          DB_W      = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      ds,
   input  logic [NKEY-1:0]  key,
   output logic [LED_W-1:0] led,
   output logic             irq,
   input  logic [31:0]      Addr,
   input  logic [3:0]       ByteEn,
   input  logic [31:0]      Din,
   output logic [31:0]      Dout
);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

   logic [NKEY-1:0]            sync1_q, sync2_q, key_db_q, key_db_d;
   logic [NKEY-1:0]            irq_en_q, irq_en_d, irq_mode_q, irq_mode_d;
   logic [NKEY-1:0]            irq_stat_q, irq_stat_d, acc, set, clr;
   logic [NKEY-1:0][DB_W-1:0]  cnt_q, cnt_d;
   logic [LED_W-1:0]           led_q, led_d;
   logic [6:0]                 sel;
   logic [31:0]                bmask;
   logic                       wr;
   logic                       unused_addr;

   assign unused_addr = ^Addr[1:0];
   assign wr          = |ByteEn;
   assign bmask       = {{8{ByteEn[3]}}, {8{ByteEn[2]}}, {8{ByteEn[1]}}, {8{ByteEn[0]}}};

   for (genvar i = 0; i < 7; i++) begin : g_sel
      assign sel[i] = Addr[31:2] == BASE_ADDR[31:2] + 30'(i);
   end

   // The counter tracks how long the synchronised key has disagreed with key_db.
   always_comb begin
      acc   = '0;
      cnt_d = '0;
      for (int k = 0; k < NKEY; k++) begin
         acc[k]   = sync2_q[k] != key_db_q[k] && cnt_q[k] == DB_MAX;
         cnt_d[k] = (sync2_q[k] == key_db_q[k] || acc[k]) ? '0 : cnt_q[k] + DB_W'(1);
      end
   end

   assign key_db_d   = key_db_q ^ acc;
   assign set        = acc & (sync2_q ^ irq_mode_q);
   assign clr        = sel[3] && wr ? Din[NKEY-1:0] & bmask[NKEY-1:0] : '0;
   assign irq_stat_d = (irq_stat_q & ~clr) | set;
   assign led_d      = sel[4] && wr ? (led_q & ~bmask[LED_W-1:0]) | (Din[LED_W-1:0] & bmask[LED_W-1:0]) : led_q;
   assign irq_en_d   = sel[5] && wr ? (irq_en_q & ~bmask[NKEY-1:0]) | (Din[NKEY-1:0] & bmask[NKEY-1:0]) : irq_en_q;
   assign irq_mode_d = sel[6] && wr ? (irq_mode_q & ~bmask[NKEY-1:0]) | (Din[NKEY-1:0] & bmask[NKEY-1:0]) : irq_mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         key_db_q   <= '0;
         cnt_q      <= '0;
         irq_stat_q <= '0;
         irq_en_q   <= '0;
         irq_mode_q <= '0;
         led_q      <= '0;
      end else begin
         sync1_q    <= key;
         sync2_q    <= sync1_q;
         key_db_q   <= key_db_d;
         cnt_q      <= cnt_d;
         irq_stat_q <= irq_stat_d;
         irq_en_q   <= irq_en_d;
         irq_mode_q <= irq_mode_d;
         led_q      <= led_d;
      end
   end

   assign led  = led_q;
   assign irq  = |(irq_stat_q & irq_en_q);
   assign Dout = sel[0] ? ds[31:0] :
                 sel[1] ? ds[63:32] :
                 sel[2] ? 32'(key_db_q) :
                 sel[3] ? 32'(irq_stat_q) :
                 sel[4] ? 32'(led_q) :
                 sel[5] ? 32'(irq_en_q) :
                 sel[6] ? 32'(irq_mode_q) : '0;
endmodule
